segre_mem_arbiter: RTL and testbench
====================================

# segre_mem_arbiter

Single-port memory arbiter and access sequencer that shares one unified memory port between instruction fetch (IF) and the load/store path (LSU) of the segre core. It takes the decoded memop controls (read/write, BYTE/HALF/WORD, sign-extend) from the LSU, builds byte enables and replicated write data, and sequences multi-cycle memory accesses. On the load path it returns aligned, extended load data. Misaligned LSU accesses are trapped locally and never reach memory.

## Interface
- WORD_SIZE, 32, data/address width
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- if_req_i  in  1  fetch request, held until if_gnt_o
- if_addr_i  in  WORD_SIZE  fetch address, word-aligned by contract
- if_gnt_o  out  1  fetch grant pulse
- if_valid_o  out  1  fetch data valid pulse
- if_rdata_o  out  WORD_SIZE  fetched instruction
- lsu_req_i  in  1  data request, payload held until lsu_gnt_o
- lsu_addr_i  in  WORD_SIZE  byte address
- lsu_wdata_i  in  WORD_SIZE  store data, in low bits
- lsu_rd_i / lsu_wr_i  in  1 each  load / store
- lsu_type_i  in  memop_data_type_e  BYTE/HALF/WORD
- lsu_sign_ext_i  in  1  sign-extend load result
- lsu_gnt_o  out  1  data grant pulse
- lsu_valid_o  out  1  completion pulse, for loads and stores
- lsu_rdata_o  out  WORD_SIZE  extended load data; 0 for stores
- lsu_misaligned_o  out  1  qualifies lsu_valid_o: access was misaligned
- mem_req_o  out  1  memory access active
- mem_we_o  out  1  write
- mem_addr_o  out  WORD_SIZE  word address, bits [1:0] forced to 0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  WORD_SIZE  replicated write data
- mem_ready_i  in  1  memory completes the current access this cycle
- mem_rdata_i  in  WORD_SIZE  read data, valid when mem_ready_i=1

## Operation
- **States:** IDLE, BUSY_IF, BUSY_LSU.
- **IDLE:**
  - Grants combinationally: if_gnt_o or lsu_gnt_o is high for one cycle.
  - On a grant edge, latches the payload and moves to BUSY_x.
  - Only one grant per cycle.
- **Arbitration:**
  - If only one requester is active, it wins.
  - If both are active, the requester not served last wins.
  - last_served resets to IF, so the LSU wins the first tie.
- **Misalignment check (LSU only):**
  - Misaligned: HALF with addr[0]=1, or WORD with addr[1:0]≠0.
  - The access is still granted, but the FSM stays in IDLE.
  - Next cycle: lsu_valid_o=1, lsu_misaligned_o=1, lsu_rdata_o=0. No memory access is issued.
- **BUSY_x:**
  - mem_req_o=1; mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o come from registers and stay stable.
  - When mem_ready_i=1, the response is registered and the FSM returns to IDLE.
  - The matching valid_o pulses the next cycle.
- **Byte enables (by lsu_type_i):**
  - BYTE: 4'b0001<<addr[1:0]
  - HALF: 4'b0011<<addr[1:0]
  - WORD: 4'b1111
  - Fetches always use 4'b1111 and mem_we_o=0.
- **Write data:**
  - BYTE: {4{wdata[7:0]}}
  - HALF: {2{wdata[15:0]}}
  - WORD: unchanged
- **Load data:**
  - Shift: d = mem_rdata_i >> (8*addr[1:0]).
  - Extend from bit 7 (BYTE) or bit 15 (HALF): sign-extend if sign_ext=1, else zero-extend.
  - WORD is passed unchanged.
- **Read/write select:** lsu_rd_i and lsu_wr_i both 1 is treated as a store. lsu_req_i with neither set completes as a no-op, exactly like a misaligned access but with lsu_misaligned_o=0.

## Timing
- **Reset values:** all outputs 0, including mem_be_o=0. State returns to IDLE, last_served=IF.
- **Reset during BUSY:** the access is abandoned. mem_req_o is 0 the cycle after the reset edge, and no valid pulse is produced.
- **Latency:** grant cycle G, mem_req_o from G+1. mem_ready_i at cycle R gives valid_o at R+1.
  - Zero-wait memory (ready at G+1): valid at G+2.
  - A new grant is allowed in the valid cycle, giving sustained throughput of one access per 2 cycles.
- **Stall:** mem_ready_i low holds BUSY indefinitely, with outputs stable.
- **Request side:** a requester must hold req and payload stable until it sees gnt. Payload changes after gnt are ignored.
- **Simultaneous events:** valid for one requester and gnt for the other may occur in the same cycle.

## Test plan
- **Single fetch:** if_req_i=1, addr 0x100, mem_ready_i at G+1, mem_rdata_i=0x00500093 → if_gnt_o at G, mem_addr_o=0x100, mem_be_o=4'hF, if_valid_o at G+2 with 0x00500093.
- **Tie break:** both requests from reset → LSU granted first; the next IDLE grants IF; a third simultaneous tie grants LSU.
- **Signed byte load:** addr 0x203, BYTE, sign_ext=1, rdata 0x80FFFFFF → mem_be_o=4'b1000, mem_addr_o=0x200, lsu_rdata_o=0xFFFFFF80. With sign_ext=0 → 0x00000080.
- **Half store:** addr 0x302, wdata 0x1234ABCD → mem_we_o=1, mem_be_o=4'b1100, mem_wdata_o=0xABCDABCD, lsu_valid_o after ready with rdata 0.
- **Misaligned word:** addr 0x401 → lsu_gnt_o, no mem_req_o, next cycle lsu_valid_o=1 and lsu_misaligned_o=1.
- **Reset mid-access:** mem_ready_i held low for 5 cycles, then rst_i high for one cycle → mem_req_o=0 next cycle, no valid pulse, and the first post-reset tie is granted to LSU.

Source files
------------

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter
//
// Shares one unified memory port between instruction fetch (IF) and the
// load/store unit (LSU). Builds byte enables and replicated write data for
// LSU stores, aligns and extends LSU load data, and traps misaligned LSU
// accesses locally so that they never reach memory.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   if_req_i/if_addr_i    fetch request and word-aligned fetch address
//   if_gnt_o              one-cycle fetch grant (combinational, IDLE only)
//   if_valid_o/if_rdata_o one-cycle fetch completion with instruction word
//   lsu_req_i ...         data request with address, store data, rd/wr,
//                         access size and sign-extend control
//   lsu_gnt_o             one-cycle data grant (combinational, IDLE only)
//   lsu_valid_o           one-cycle completion for loads, stores, no-ops
//   lsu_rdata_o           extended load data, 0 for stores and no-ops
//   lsu_misaligned_o      qualifies lsu_valid_o: access was trapped
//   mem_*                 unified memory port; mem_ready_i ends an access
//
// Handshake: a requester raises req with a stable payload and keeps both
// until it sees its gnt pulse; the payload is latched on the grant edge and
// later changes are ignored. Completion is a single-cycle valid pulse one
// cycle after the memory reports mem_ready_i (or one cycle after the grant
// for trapped/no-op LSU accesses). Memory side: mem_req_o stays high with a
// stable command until the cycle where mem_ready_i is sampled high.

package segre_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;
endpackage

module segre_mem_arbiter
  import segre_mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // instruction fetch
  input  logic                 if_req_i,
  input  logic [WORD_SIZE-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_valid_o,
  output logic [WORD_SIZE-1:0] if_rdata_o,
  // load/store unit
  input  logic                 lsu_req_i,
  input  logic [WORD_SIZE-1:0] lsu_addr_i,
  input  logic [WORD_SIZE-1:0] lsu_wdata_i,
  input  logic                 lsu_rd_i,
  input  logic                 lsu_wr_i,
  input  memop_data_type_e     lsu_type_i,
  input  logic                 lsu_sign_ext_i,
  output logic                 lsu_gnt_o,
  output logic                 lsu_valid_o,
  output logic [WORD_SIZE-1:0] lsu_rdata_o,
  output logic                 lsu_misaligned_o,
  // unified memory port
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic [3:0]           mem_be_o,
  output logic [WORD_SIZE-1:0] mem_wdata_o,
  input  logic                 mem_ready_i,
  input  logic [WORD_SIZE-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_LSU = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_lsu_q, last_lsu_d;   // 0: IF served last
  logic                   mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]             mem_be_q, mem_be_d;
  logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]             lsu_off_q, lsu_off_d;
  memop_data_type_e       lsu_type_q, lsu_type_d;
  logic                   lsu_sext_q, lsu_sext_d;
  logic                   if_valid_q, if_valid_d;
  logic [WORD_SIZE-1:0]   if_rdata_q, if_rdata_d;
  logic                   lsu_valid_q, lsu_valid_d;
  logic [WORD_SIZE-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                   lsu_mis_q, lsu_mis_d;

  // Fetch addresses are word-aligned by contract; the low bits are dropped.
  logic unused_if_addr_bits;
  assign unused_if_addr_bits = ^if_addr_i[1:0];

  // ---------------------------------------------------------------------
  // Arbitration: the LSU wins when it is alone or when IF was served last.
  // ---------------------------------------------------------------------
  logic in_idle;
  logic lsu_wins;
  logic if_gnt;
  logic lsu_gnt;

  assign in_idle  = (state_q == IDLE) && !rst_i;
  assign lsu_wins = lsu_req_i && (!if_req_i || !last_lsu_q);
  assign lsu_gnt  = in_idle && lsu_wins;
  assign if_gnt   = in_idle && if_req_i && !lsu_wins;

  // ---------------------------------------------------------------------
  // LSU request decode: byte enables, lane-replicated store data, alignment.
  // ---------------------------------------------------------------------
  logic [1:0]           req_off;
  logic [3:0]           req_be;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 req_align_err;
  logic                 req_noop;
  logic                 req_trap;

  assign req_off = lsu_addr_i[1:0];

  always_comb begin
    req_be        = 4'b1111;
    req_wdata     = lsu_wdata_i;
    req_align_err = 1'b0;
    unique case (lsu_type_i)
      BYTE: begin
        req_be    = 4'b0001 << req_off;
        req_wdata = {4{lsu_wdata_i[7:0]}};
      end
      HALF: begin
        req_be        = 4'b0011 << req_off;
        req_wdata     = {2{lsu_wdata_i[15:0]}};
        req_align_err = req_off[0];
      end
      default: begin
        req_align_err = (req_off != 2'b00);
      end
    endcase
  end

  // Neither rd nor wr: completes like a trapped access but is not flagged.
  assign req_noop = !lsu_rd_i && !lsu_wr_i;
  assign req_trap = req_noop || req_align_err;

  // ---------------------------------------------------------------------
  // Load data: move the addressed lane down to bit 0, then extend.
  // ---------------------------------------------------------------------
  logic [WORD_SIZE-1:0] load_shifted;
  logic [WORD_SIZE-1:0] load_ext;

  assign load_shifted = mem_rdata_i >> {lsu_off_q, 3'b000};

  always_comb begin
    load_ext = mem_rdata_i;
    unique case (lsu_type_q)
      BYTE:    load_ext = {{24{lsu_sext_q & load_shifted[7]}}, load_shifted[7:0]};
      HALF:    load_ext = {{16{lsu_sext_q & load_shifted[15]}}, load_shifted[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_lsu_d  = last_lsu_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    lsu_off_d   = lsu_off_q;
    lsu_type_d  = lsu_type_q;
    lsu_sext_d  = lsu_sext_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    lsu_valid_d = 1'b0;
    lsu_rdata_d = lsu_rdata_q;
    lsu_mis_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (lsu_gnt) begin
          last_lsu_d = 1'b1;
          if (req_trap) begin
            // Trapped or no-op access: answer locally next cycle, stay IDLE.
            lsu_valid_d = 1'b1;
            lsu_mis_d   = req_align_err && !req_noop;
            lsu_rdata_d = '0;
          end else begin
            state_d     = BUSY_LSU;
            mem_we_d    = lsu_wr_i;   // rd and wr together is a store
            mem_addr_d  = {lsu_addr_i[WORD_SIZE-1:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = lsu_wr_i ? req_wdata : '0;
            lsu_off_d   = req_off;
            lsu_type_d  = lsu_type_i;
            lsu_sext_d  = lsu_sign_ext_i;
          end
        end else if (if_gnt) begin
          last_lsu_d  = 1'b0;
          state_d     = BUSY_IF;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr_i[WORD_SIZE-1:2], 2'b00};
          mem_be_d    = 4'b1111;
          mem_wdata_d = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ready_i) begin
          state_d     = IDLE;
          if_valid_d  = 1'b1;
          if_rdata_d  = mem_rdata_i;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = 4'b0000;
          mem_wdata_d = '0;
        end
      end
      BUSY_LSU: begin
        if (mem_ready_i) begin
          state_d     = IDLE;
          lsu_valid_d = 1'b1;
          lsu_rdata_d = mem_we_q ? '0 : load_ext;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = 4'b0000;
          mem_wdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_lsu_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      lsu_off_q   <= 2'b00;
      lsu_type_q  <= BYTE;
      lsu_sext_q  <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      lsu_valid_q <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_lsu_q  <= last_lsu_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      lsu_off_q   <= lsu_off_d;
      lsu_type_q  <= lsu_type_d;
      lsu_sext_q  <= lsu_sext_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      lsu_valid_q <= lsu_valid_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_mis_q   <= lsu_mis_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign if_gnt_o         = if_gnt;
  assign lsu_gnt_o        = lsu_gnt;
  assign if_valid_o       = if_valid_q;
  assign if_rdata_o       = if_rdata_q;
  assign lsu_valid_o      = lsu_valid_q;
  assign lsu_rdata_o      = lsu_rdata_q;
  assign lsu_misaligned_o = lsu_mis_q;
  assign mem_req_o        = (state_q != IDLE);
  assign mem_we_o         = mem_we_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_be_o         = mem_be_q;
  assign mem_wdata_o      = mem_wdata_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Testbench for segre_mem_arbiter: directed test-plan scenarios followed by
// randomized single and contended requests, checked against a
// transaction-level reference model of the arbitration and lane rules.

module tb_segre_mem_arbiter;
  import segre_mem_arbiter_pkg::*;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_gnt;
  logic             if_valid;
  logic [31:0]      if_rdata;
  logic             lsu_req;
  logic [31:0]      lsu_addr;
  logic [31:0]      lsu_wdata;
  logic             lsu_rd;
  logic             lsu_wr;
  memop_data_type_e lsu_type;
  logic             lsu_sext;
  logic             lsu_gnt;
  logic             lsu_valid;
  logic [31:0]      lsu_rdata;
  logic             lsu_mis;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;
  logic             mem_ready;
  logic [31:0]      mem_rdata;

  segre_mem_arbiter #(.WORD_SIZE(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_req_i         (if_req),
    .if_addr_i        (if_addr),
    .if_gnt_o         (if_gnt),
    .if_valid_o       (if_valid),
    .if_rdata_o       (if_rdata),
    .lsu_req_i        (lsu_req),
    .lsu_addr_i       (lsu_addr),
    .lsu_wdata_i      (lsu_wdata),
    .lsu_rd_i         (lsu_rd),
    .lsu_wr_i         (lsu_wr),
    .lsu_type_i       (lsu_type),
    .lsu_sign_ext_i   (lsu_sext),
    .lsu_gnt_o        (lsu_gnt),
    .lsu_valid_o      (lsu_valid),
    .lsu_rdata_o      (lsu_rdata),
    .lsu_misaligned_o (lsu_mis),
    .mem_req_o        (mem_req),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_be_o         (mem_be),
    .mem_wdata_o      (mem_wdata),
    .mem_ready_i      (mem_ready),
    .mem_rdata_i      (mem_rdata)
  );

  // -------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  bit model_last_lsu;            // which requester the model served last
  logic        seen_we;          // memory command observed in the last access
  logic [31:0] seen_addr;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  logic [31:0] seen_rdata;       // data observed with the last valid pulse
  logic        seen_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------
  // Reference model: size/lane arithmetic
  // -------------------------------------------------------------------
  function automatic int ref_nbytes(input logic [1:0] t);
    case (t)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] t, input logic [31:0] a);
    return (int'(a[1:0]) % ref_nbytes(t)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] t, input logic [31:0] a);
    int nb;
    int off;
    nb  = ref_nbytes(t);
    off = int'(a[1:0]);
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] t, input logic [31:0] w);
    logic [31:0] r;
    int nb;
    nb = ref_nbytes(t);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] t, input logic sext,
                                           input logic [31:0] a, input logic [31:0] rd);
    longint v;
    longint span;
    int nb;
    nb   = ref_nbytes(t);
    span = longint'(1) << (8 * nb);
    v    = longint'(rd) >> (8 * int'(a[1:0]));
    v    = v % span;
    if (sext && nb < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // -------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------
  task automatic rand_lsu();
    int t;
    int op;
    t         = $urandom_range(0, 2);
    lsu_type  = memop_data_type_e'(2'(t));
    lsu_addr  = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      if (t == 1) lsu_addr[0] = 1'b0;
      if (t == 2) lsu_addr[1:0] = 2'b00;
    end
    op        = $urandom_range(0, 7);
    lsu_rd    = (op <= 2) || (op == 6);
    lsu_wr    = (op >= 3) && (op <= 6);
    lsu_sext  = 1'($urandom_range(0, 1));
    lsu_wdata = $urandom;
  endtask

  task automatic rand_if();
    if_addr = $urandom;
    if_addr[1:0] = 2'b00;
  endtask

  task automatic set_lsu(input logic [31:0] a, input memop_data_type_e t, input logic rd,
                         input logic wr, input logic sx, input logic [31:0] wd);
    lsu_addr = a; lsu_type = t; lsu_rd = rd; lsu_wr = wr; lsu_sext = sx; lsu_wdata = wd;
  endtask

  // Starts at the sample point of the grant cycle, ends at the sample point
  // of the completion cycle (where a pending requester may be granted).
  task automatic serve_one(input bit is_lsu, input int wait_n, input logic [31:0] rdata);
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    bit          e_we;
    bit          e_mis;
    bit          skip;
    bit          noop;

    check("if_gnt", 32'(if_gnt), 32'(!is_lsu));
    check("lsu_gnt", 32'(lsu_gnt), 32'(is_lsu));
    model_last_lsu = is_lsu;

    skip  = 1'b0;
    e_mis = 1'b0;
    if (is_lsu) begin
      noop    = !lsu_rd && !lsu_wr;
      e_mis   = !noop && ref_misaligned(lsu_type, lsu_addr);
      skip    = noop || e_mis;
      e_we    = lsu_wr;
      e_addr  = {lsu_addr[31:2], 2'b00};
      e_be    = ref_be(lsu_type, lsu_addr);
      e_wdata = ref_wdata(lsu_type, lsu_wdata);
      e_rdata = lsu_wr ? 32'h0 : ref_load(lsu_type, lsu_sext, lsu_addr, rdata);
    end else begin
      e_we    = 1'b0;
      e_addr  = if_addr;
      e_be    = 4'hF;
      e_wdata = 32'h0;
      e_rdata = rdata;
    end

    to_drive();
    // Payload after the grant must be ignored: drop req and scramble it.
    if (is_lsu) begin
      lsu_req = 1'b0;
      rand_lsu();
    end else begin
      if_req = 1'b0;
      rand_if();
    end

    if (skip) begin
      mem_ready = 1'b0;
      to_sample();
      check("trap_mem_req", 32'(mem_req), 32'h0);
      check("trap_valid", 32'(lsu_valid), 32'h1);
      check("trap_mis", 32'(lsu_mis), 32'(e_mis));
      check("trap_rdata", lsu_rdata, 32'h0);
      seen_mis   = lsu_mis;
      seen_rdata = lsu_rdata;
      return;
    end

    for (int k = 0; k <= wait_n; k++) begin
      mem_ready = (k == wait_n);
      mem_rdata = (k == wait_n) ? rdata : $urandom;
      to_sample();
      check("mem_req", 32'(mem_req), 32'h1);
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_addr", mem_addr, e_addr);
      check("mem_be", 32'(mem_be), 32'(e_be));
      if (e_we) check("mem_wdata", mem_wdata, e_wdata);
      check("busy_no_gnt", 32'({if_gnt, lsu_gnt}), 32'h0);
      check("busy_no_valid", 32'({if_valid, lsu_valid}), 32'h0);
      if (k == 0) begin
        seen_we = mem_we; seen_addr = mem_addr; seen_be = mem_be; seen_wdata = mem_wdata;
      end
      to_drive();
    end

    mem_ready = 1'b0;
    mem_rdata = $urandom;
    to_sample();
    if (is_lsu) begin
      check("lsu_valid", 32'(lsu_valid), 32'h1);
      check("if_valid_idle", 32'(if_valid), 32'h0);
      check("lsu_rdata", lsu_rdata, e_rdata);
      check("lsu_mis_clear", 32'(lsu_mis), 32'h0);
      seen_rdata = lsu_rdata;
      seen_mis   = lsu_mis;
    end else begin
      check("if_valid", 32'(if_valid), 32'h1);
      check("lsu_valid_idle", 32'(lsu_valid), 32'h0);
      check("if_rdata", if_rdata, e_rdata);
      seen_rdata = if_rdata;
    end
  endtask

  // One arbitration round from IDLE; with both requesting, the model picks
  // the requester not served last and the other follows at its valid cycle.
  task automatic txn(input bit want_if, input bit want_lsu, input int wait_a,
                     input int wait_b, input logic [31:0] rd_a, input logic [31:0] rd_b);
    bit first_lsu;
    if_req  = want_if;
    lsu_req = want_lsu;
    to_sample();
    if (want_if && want_lsu) begin
      first_lsu = !model_last_lsu;
      serve_one(first_lsu, wait_a, rd_a);
      serve_one(!first_lsu, wait_b, rd_b);
    end else if (want_lsu) begin
      serve_one(1'b1, wait_a, rd_a);
    end else if (want_if) begin
      serve_one(1'b0, wait_a, rd_a);
    end
    to_drive();
    to_sample();
    check("valid_one_cycle", 32'({if_valid, lsu_valid}), 32'h0);
    to_drive();
  endtask

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin
    rst = 1'b1; if_req = 1'b0; lsu_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    if_addr = '0;
    set_lsu(32'h0, BYTE, 1'b0, 1'b0, 1'b0, 32'h0);
    model_last_lsu = 1'b0;
    seen_we = 1'b0; seen_addr = '0; seen_be = '0; seen_wdata = '0; seen_rdata = '0; seen_mis = 1'b0;

    // Reset values
    repeat (2) to_drive();
    to_sample();
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_valids", 32'({if_valid, lsu_valid, lsu_mis, mem_we}), 32'h0);
    check("rst_rdata", if_rdata | lsu_rdata | mem_wdata, 32'h0);
    to_drive();
    rst = 1'b0;

    // Tie from reset: LSU, then IF, then a second tie goes to LSU again
    set_lsu(32'h600, WORD, 1'b1, 1'b0, 1'b0, 32'h0);
    if_addr = 32'h80;
    txn(1'b1, 1'b1, 0, 1, 32'hCAFEF00D, 32'h11223344);
    set_lsu(32'h604, WORD, 1'b1, 1'b0, 1'b0, 32'h0);
    if_addr = 32'h84;
    txn(1'b1, 1'b1, 1, 0, 32'h55667788, 32'h99AABBCC);

    // Single fetch with zero-wait memory
    if_addr = 32'h100;
    txn(1'b1, 1'b0, 0, 0, 32'h00500093, 32'h0);
    check("fetch_addr", seen_addr, 32'h100);
    check("fetch_be", 32'(seen_be), 32'hF);
    check("fetch_rdata", seen_rdata, 32'h00500093);

    // Signed and unsigned byte load from the top lane
    set_lsu(32'h203, BYTE, 1'b1, 1'b0, 1'b1, 32'h0);
    txn(1'b0, 1'b1, 0, 0, 32'h80FFFFFF, 32'h0);
    check("sb_be", 32'(seen_be), 32'h8);
    check("sb_addr", seen_addr, 32'h200);
    check("sb_rdata", seen_rdata, 32'hFFFFFF80);
    set_lsu(32'h203, BYTE, 1'b1, 1'b0, 1'b0, 32'h0);
    txn(1'b0, 1'b1, 2, 0, 32'h80FFFFFF, 32'h0);
    check("ub_rdata", seen_rdata, 32'h00000080);

    // Half store to the upper lane
    set_lsu(32'h302, HALF, 1'b0, 1'b1, 1'b0, 32'h1234ABCD);
    txn(1'b0, 1'b1, 1, 0, 32'hDEADBEEF, 32'h0);
    check("sh_we", 32'(seen_we), 32'h1);
    check("sh_be", 32'(seen_be), 32'hC);
    check("sh_wdata", seen_wdata, 32'hABCDABCD);
    check("sh_rdata", seen_rdata, 32'h0);

    // rd and wr together is a store
    set_lsu(32'h310, WORD, 1'b1, 1'b1, 1'b0, 32'h0BADC0DE);
    txn(1'b0, 1'b1, 0, 0, 32'hFFFFFFFF, 32'h0);
    check("rdwr_we", 32'(seen_we), 32'h1);

    // Misaligned word and a no-op request
    set_lsu(32'h401, WORD, 1'b1, 1'b0, 1'b0, 32'h0);
    txn(1'b0, 1'b1, 0, 0, 32'h0, 32'h0);
    check("misaligned_flag", 32'(seen_mis), 32'h1);
    set_lsu(32'h402, HALF, 1'b0, 1'b0, 1'b0, 32'h0);
    txn(1'b0, 1'b1, 0, 0, 32'h0, 32'h0);
    check("noop_flag", 32'(seen_mis), 32'h0);

    // Reset mid-access: stall a fetch, reset, then tie goes to LSU
    if_req  = 1'b1;
    if_addr = 32'h500;
    to_sample();
    check("rm_if_gnt", 32'(if_gnt), 32'h1);
    to_drive();
    if_req = 1'b0;
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      to_sample();
      check("rm_stall_req", 32'(mem_req), 32'h1);
      check("rm_stall_addr", mem_addr, 32'h500);
      to_drive();
    end
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    model_last_lsu = 1'b0;
    to_sample();
    check("rm_req_dropped", 32'(mem_req), 32'h0);
    check("rm_no_valid", 32'({if_valid, lsu_valid}), 32'h0);
    to_drive();
    set_lsu(32'h700, WORD, 1'b1, 1'b0, 1'b0, 32'h0);
    if_addr = 32'h504;
    txn(1'b1, 1'b1, 0, 0, 32'h13572468, 32'h24681357);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int choice;
      choice = $urandom_range(0, 3);
      rand_lsu();
      rand_if();
      txn(choice != 1, choice != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of stimulus, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
